mem_access_unit: RTL

- Load/store stage directly downstream of the ALU; takes the ALU result as the effective address and the rt value as store data.
- Runs one memory transaction per start over a req/ack bus to data memory, with byte-lane steering and load sign/zero extension.
- Reports misaligned accesses and bus timeouts; drives busy so the control path can stall.

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/load_extend.sv | 35 +++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store unit.
//   size_e  : access size encodings (byte/half/word/reserved)
//   state_e : transaction FSM states
//   LANES   : byte lanes per data word
package mem_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned TO_W  = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Alignment/size fault: reserved size or a half/word not on its natural boundary.
    function automatic logic is_misaligned(size_e sz, logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for an aligned access.
    function automatic logic [LANES-1:0] byte_enables(size_e sz, logic [1:0] off);
        logic [LANES-1:0] be;
        case (sz)
            SZ_BYTE: be = LANES'(1) << off;
            SZ_HALF: be = off[1] ? LANES'(4'b1100) : LANES'(4'b0011);
            default: be = '1;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select plus sign/zero extension.
//   word     : raw word returned by memory
//   off      : byte offset (addr[1:0]) of the access
//   size     : access size
//   sign_ext : 1 sign-extend, 0 zero-extend
//   data     : extended load result
module load_extend
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  size_e             size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] data
);

    localparam int unsigned BYTE_W = DATA_W / LANES;
    localparam int unsigned HALF_W = 2 * BYTE_W;

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    always_comb begin
        byte_lane = word[32'(off) * BYTE_W +: BYTE_W];
        half_lane = word[32'(off[1]) * HALF_W +: HALF_W];
        case (size)
            SZ_BYTE: data = {{(DATA_W - BYTE_W){sign_ext & byte_lane[BYTE_W-1]}}, byte_lane};
            SZ_HALF: data = {{(DATA_W - HALF_W){sign_ext & half_lane[HALF_W-1]}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one req/ack memory transaction per start.
//   start/is_store/size/sign_ext/addr/wdata : request from execute stage
//   busy/done/rdata/misalign/bus_err        : status back to the pipeline
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata: data memory bus request
//   mem_ack/mem_rdata                       : data memory bus response
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned BYTE_W = DATA_W / LANES;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              is_store_q, is_store_d;
    size_e             size_q, size_d;
    logic              sign_ext_q, sign_ext_d;
    logic [1:0]        off_q, off_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LANES-1:0]  mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ext_data;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .word     (mem_rdata),
        .off      (off_q),
        .size     (size_q),
        .sign_ext (sign_ext_q),
        .data     (ext_data)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_ext_q  <= 1'b0;
            off_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            sign_ext_q  <= sign_ext_d;
            off_q       <= off_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state, bus steering and status pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        sign_ext_d  = sign_ext_q;
        off_d       = off_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rdata_d     = '0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    size_d     = size_e'(size);
                    sign_ext_d = sign_ext;
                    off_d      = addr[1:0];
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    if (is_misaligned(size_e'(size), addr[1:0])) begin
                        state_d    = ST_RESP;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = is_store;
                        mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                        mem_be_d   = byte_enables(size_e'(size), addr[1:0]);
                        case (size_e'(size))
                            SZ_BYTE: mem_wdata_d = {LANES{wdata[BYTE_W-1:0]}};
                            SZ_HALF: mem_wdata_d = {(LANES / 2){wdata[2*BYTE_W-1:0]}};
                            default: mem_wdata_d = wdata;
                        endcase
                    end
                end
            end
            ST_REQ: begin
                // Ack on the final allowed cycle still completes normally.
                if (mem_ack || (cnt_q == TO_W'(TIMEOUT - 1))) begin
                    state_d     = ST_RESP;
                    done_d      = 1'b1;
                    bus_err_d   = ~mem_ack;
                    rdata_d     = (mem_ack && !is_store_q) ? ext_data : '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
